// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the frame-level AXI-Stream arbiter.
//   arb_state_e : arbiter FSM states (idle / locked onto one source).
//   rr_pick     : round-robin search over a request vector, starting at ptr
//                 and wrapping from n_ports-1 back to 0.
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Request vectors are zero-extended to this width so one function
    // serves every port count up to 32.
    localparam int RR_MAX_PORTS = 32;

    // Returns the first index at or above ptr (modulo n_ports) whose request
    // bit is set. If nothing is requested, ptr is returned unchanged.
    function automatic int rr_pick(
        input logic [RR_MAX_PORTS-1:0] req,
        input int                      ptr,
        input int                      n_ports
    );
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_PORTS; i++) begin
            if (i < n_ports) begin
                idx = (ptr + i) % n_ports;
                if (!found && req[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_frame_arbiter_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Two-entry AXI-Stream skid buffer. Both ready and valid come straight from
// flops, so there is no combinational path between in_* and out_* handshakes.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/valid/ready   : upstream side (payload of WIDTH bits)
//   out_data/valid/ready  : downstream side
// ---------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    // The head entry is never overwritten while held, which keeps out_data
    // stable across downstream stalls.
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_arbiter
// Round-robin arbiter sharing one AXI-Stream byte channel between N_PORTS
// sources. A grant is held from the first beat of a frame through its tlast
// beat, so frames never interleave. The output goes through axis_reg_slice.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   s_tdata/tvalid/tlast/tready : N_PORTS slave streams (port k at
//                                 s_tdata[k*DATA_WIDTH +: DATA_WIDTH])
//   m_tdata/tvalid/tlast/tready : merged master stream
//   m_tid                       : source port of the current master beat
// ---------------------------------------------------------------------------
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int N_PORTS    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_PORTS-1:0]            s_tvalid,
    input  logic [N_PORTS-1:0]            s_tlast,
    output logic [N_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [ID_WIDTH-1:0]           m_tid,
    input  logic                          m_tready
);

    localparam int PAYLOAD_W = DATA_WIDTH + 1 + ID_WIDTH;

    arb_state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]       grant_q, grant_d;
    logic [RR_MAX_PORTS-1:0]   req_ext;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      sel_last;
    logic                      slice_in_valid;
    logic                      slice_in_ready;
    logic [PAYLOAD_W-1:0]      slice_in_data;
    logic [PAYLOAD_W-1:0]      slice_out_data;

    always_comb begin
        req_ext              = '0;
        req_ext[N_PORTS-1:0] = s_tvalid;
    end

    assign sel_data      = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last      = s_tlast[grant_q];
    assign slice_in_data = {sel_data, sel_last, grant_q};

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        s_tready       = '0;
        slice_in_valid = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|s_tvalid) begin
                    grant_d = ID_WIDTH'(rr_pick(req_ext, int'(rr_ptr_q), N_PORTS));
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // The grant survives a source dropping tvalid mid-frame; only
                // an accepted tlast beat releases it.
                slice_in_valid    = s_tvalid[grant_q];
                s_tready[grant_q] = slice_in_ready;
                if (slice_in_valid && slice_in_ready && sel_last) begin
                    // The port that just finished becomes lowest priority.
                    rr_ptr_d = (grant_q == ID_WIDTH'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    axis_reg_slice #(
        .WIDTH (PAYLOAD_W)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (slice_in_data),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  (slice_out_data),
        .out_valid (m_tvalid),
        .out_ready (m_tready)
    );

    assign m_tdata = slice_out_data[PAYLOAD_W-1 -: DATA_WIDTH];
    assign m_tlast = slice_out_data[ID_WIDTH];
    assign m_tid   = slice_out_data[ID_WIDTH-1:0];

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_arbiter
// Self-checking bench for axis_frame_arbiter: per-port source queues feed the
// slave ports, a per-port expected queue is popped as master beats leave, and
// output/acceptance logs are inspected for ordering and timing.
// ---------------------------------------------------------------------------
module tb_axis_frame_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              m_tready = 1'b1;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .N_PORTS    (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tready (m_tready)
    );

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    typedef struct { int tid; int d; int l; int cyc; } obeat_t;
    typedef struct { int port; int cyc; } acc_t;
    typedef struct { int first_port; logic [3:0] mask; int exp_tid; } rr_vec_t;

    beat_t  srcq [NP][$];
    beat_t  expq [NP][$];
    obeat_t outlog[$];
    acc_t   acclog[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gap_pct = 0;
    bit rdy_rand = 1'b0;
    bit rdy_fix = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l);
        srcq[p].push_back('{d, l});
        expq[p].push_back('{d, l});
    endtask

    function automatic bit busy();
        for (int k = 0; k < NP; k++)
            if (srcq[k].size() != 0 || expq[k].size() != 0) return 1'b1;
        return m_tvalid;
    endfunction

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while (busy() && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (busy()) begin
            total++;
            bad++;
            $display("FAIL %s timeout: still busy after %0d cycles, required idle", nm, maxc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < NP; k++) begin
            srcq[k].delete();
            expq[k].delete();
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        outlog.delete();
        acclog.delete();
    endtask

    // Source driver: holds each beat until accepted, optional random gaps
    // before presenting a new beat.
    initial begin
        bit [NP-1:0] acc;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NP; k++) begin
                if (acc[k] && srcq[k].size() != 0) void'(srcq[k].pop_front());
                if (srcq[k].size() == 0) begin
                    s_tvalid[k] = 1'b0;
                end else if (!s_tvalid[k] || acc[k]) begin
                    if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                        s_tvalid[k] = 1'b0;
                    end else begin
                        s_tvalid[k]        = 1'b1;
                        s_tdata[k*DW +: DW] = srcq[k][0].d;
                        s_tlast[k]         = srcq[k][0].l;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_rand ? 1'($urandom_range(1)) : rdy_fix;
        end
    end

    // Monitor: scoreboard, AXIS stability, one-hot ready, logs.
    initial begin
        bit          prev_stall;
        logic [10:0] snap;
        beat_t       e;
        prev_stall = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("ready_onehot0", longint'($countones(s_tready) <= 1), 1);
                if (prev_stall)
                    chk("m_stable", {m_tvalid, m_tdata, m_tlast, m_tid}, {1'b1, snap});
                for (int k = 0; k < NP; k++)
                    if (s_tvalid[k] && s_tready[k]) acclog.push_back('{k, cyc});
                if (m_tvalid && m_tready) begin
                    outlog.push_back('{int'(m_tid), int'(m_tdata), int'(m_tlast), cyc});
                    if (expq[m_tid].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got beat 0x%0h on tid %0d, required none", m_tdata, m_tid);
                    end else begin
                        e = expq[m_tid].pop_front();
                        chk("sb_data", m_tdata, e.d);
                        chk("sb_last", m_tlast, e.l);
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                snap = {m_tdata, m_tlast, m_tid};
            end
        end
    end

    initial begin
        rr_vec_t vecs[6];
        int      L;
        int      n;
        int      len;
        int      t2d[3];
        int      lasts[$];

        // {setup port (sets rr_ptr to port+1), simultaneous request mask, expected first grant}
        vecs[0] = '{0, 4'b1111, 1};
        vecs[1] = '{1, 4'b0011, 0};
        vecs[2] = '{3, 4'b1001, 0};
        vecs[3] = '{2, 4'b0100, 2};
        vecs[4] = '{0, 4'b0101, 2};
        vecs[5] = '{2, 4'b1011, 3};
        t2d[0] = 8'h11;
        t2d[1] = 8'h22;
        t2d[2] = 8'h33;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tid", m_tid, 0);
        chk("rst_s_tready", s_tready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_m_tvalid", m_tvalid, 0);

        // Single 3-beat frame from port 0
        do_reset();
        @(negedge clk);
        L = cyc;
        push_beat(0, 8'h11, 1'b0);
        push_beat(0, 8'h22, 1'b0);
        push_beat(0, 8'h33, 1'b1);
        wait_idle(100, "t_frame3");
        chk("frame3_count", outlog.size(), 3);
        if (outlog.size() == 3 && acclog.size() != 0) begin
            chk("frame3_ready_lat", acclog[0].cyc - L, 2);
            chk("frame3_out_lat", outlog[0].cyc - acclog[0].cyc, 1);
            for (int i = 0; i < 3; i++) begin
                chk("frame3_data", outlog[i].d, t2d[i]);
                chk("frame3_last", outlog[i].l, (i == 2) ? 1 : 0);
                chk("frame3_tid", outlog[i].tid, 0);
                if (i > 0) chk("frame3_consec", outlog[i].cyc - outlog[i-1].cyc, 1);
            end
        end

        // All four ports, 2-beat frames, simultaneous after reset
        do_reset();
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            push_beat(p, 8'(8'h40 + 2*p), 1'b0);
            push_beat(p, 8'(8'h41 + 2*p), 1'b1);
        end
        wait_idle(200, "t_all4");
        chk("all4_count", outlog.size(), 8);
        chk("all4_acc_count", acclog.size(), 8);
        if (outlog.size() == 8 && acclog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("all4_tid", outlog[i].tid, i / 2);
                if (i > 0) begin
                    chk("all4_out_gap", outlog[i].cyc - outlog[i-1].cyc, (i % 2 == 1) ? 1 : 2);
                    chk("all4_acc_gap", acclog[i].cyc - acclog[i-1].cyc, (i % 2 == 1) ? 1 : 2);
                end
            end
        end

        // Back-to-back single-beat frames from ports 0 and 1
        do_reset();
        @(negedge clk);
        push_beat(0, 8'h01, 1'b1);
        push_beat(1, 8'h02, 1'b1);
        wait_idle(100, "t_single");
        chk("single_count", outlog.size(), 2);
        if (outlog.size() == 2 && acclog.size() == 2) begin
            chk("single_d0", outlog[0].d, 8'h01);
            chk("single_tid0", outlog[0].tid, 0);
            chk("single_l0", outlog[0].l, 1);
            chk("single_d1", outlog[1].d, 8'h02);
            chk("single_tid1", outlog[1].tid, 1);
            chk("single_l1", outlog[1].l, 1);
            chk("single_acc_gap", acclog[1].cyc - acclog[0].cyc, 2);
        end

        // Round-robin priority table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push_beat(vecs[i].first_port, 8'(8'hC0 + i), 1'b1);
            wait_idle(100, "t_rr_setup");
            outlog.delete();
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                if (vecs[i].mask[p]) push_beat(p, 8'(8'hD0 + p), 1'b1);
            wait_idle(100, "t_rr");
            chk("rr_count", outlog.size(), $countones(vecs[i].mask));
            if (outlog.size() != 0) chk("rr_first_tid", outlog[0].tid, vecs[i].exp_tid);
        end

        // Ports 1 and 2 requesting continuously
        do_reset();
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            for (int p = 1; p <= 2; p++) begin
                push_beat(p, 8'(p*16 + 2*f), 1'b0);
                push_beat(p, 8'(p*16 + 2*f + 1), 1'b1);
            end
        end
        wait_idle(200, "t_alt");
        lasts.delete();
        foreach (outlog[i]) if (outlog[i].l != 0) lasts.push_back(outlog[i].tid);
        chk("alt_frames", lasts.size(), 8);
        foreach (lasts[j]) chk("alt_tid", lasts[j], (j % 2 == 0) ? 1 : 2);

        // Reset mid-frame on port 2, then a single beat from port 3
        do_reset();
        rdy_fix = 1'b0;
        @(negedge clk);
        push_beat(2, 8'h51, 1'b0);
        push_beat(2, 8'h52, 1'b0);
        push_beat(2, 8'h53, 1'b0);
        push_beat(2, 8'h54, 1'b1);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_started", m_tvalid, 1);
        chk("midrst_ready_pre", s_tready, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        srcq[2].delete();
        expq[2].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_fix = 1'b1;
        @(negedge clk);
        outlog.delete();
        push_beat(3, 8'hA5, 1'b1);
        wait_idle(100, "t_midrst");
        chk("midrst_count", outlog.size(), 1);
        if (outlog.size() == 1) begin
            chk("midrst_tid", outlog[0].tid, 3);
            chk("midrst_data", outlog[0].d, 8'hA5);
            chk("midrst_last", outlog[0].l, 1);
        end

        // Randomised traffic: 200 frames per port, random gaps and m_tready
        do_reset();
        gap_pct = 30;
        rdy_rand = 1'b1;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            for (int f = 0; f < 200; f++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++)
                    push_beat(p, 8'($urandom_range(255)), (b == len - 1));
            end
        end
        wait_idle(60000, "t_random");
        gap_pct = 0;
        rdy_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
